// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB, waits on the
// memory ready handshake with an optional timeout, and counts retired instructions.
module multicycle_control #(
  parameter int OPCODE_W    = 11,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                reg2loc_o,
  output logic                alu_src_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic                instr_done_o,
  output logic [CNT_W-1:0]    retired_o,
  output logic                fault_o,
  output logic                illegal_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B, C_ILLEGAL
  } class_e;

  localparam logic [1:0]         PC_SEQ = 2'b00;
  localparam logic [1:0]         PC_BR  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_CB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2);

  // The counter only needs to reach MEM_TIMEOUT-1: the expiring cycle goes straight to FAULT.
  localparam int               WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);

  state_e            state_q, state_d;
  class_e            class_q, class_d, dec_class;
  logic              illegal_q, illegal_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              expired;

  always_comb begin
    dec_class = C_ILLEGAL;
    casez (opcode_i)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: dec_class = C_RTYPE;
      11'b11111000010:                  dec_class = C_LDUR;
      11'b11111000000:                  dec_class = C_STUR;
      11'b10110100???:                  dec_class = C_CBZ;
      11'b10110101???:                  dec_class = C_CBNZ;
      11'b000101?????:                  dec_class = C_B;
      default:                          dec_class = C_ILLEGAL;
    endcase
  end

  assign expired = TIMEOUT_EN && (wait_q == WAIT_LAST) && !mem_ready_i;

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    illegal_d    = illegal_q;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SEQ;
    reg2loc_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_op_o     = ALU_ADD;
    instr_done_o = 1'b0;
    fault_o      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_class == C_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_FAULT;
        end else if (dec_class == C_B) begin
          pc_write_o   = 1'b1;
          pc_src_o     = PC_BR;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_RTYPE: begin
            alu_op_o = ALU_R;
            state_d  = S_WB;
          end
          C_LDUR, C_STUR: begin
            reg2loc_o = 1'b1;
            alu_src_o = 1'b1;
            state_d   = S_MEM;
          end
          C_CBZ, C_CBNZ: begin
            reg2loc_o = 1'b1;
            alu_op_o  = ALU_CB;
            if ((class_q == C_CBZ) == zero_i) begin
              pc_write_o = 1'b1;
              pc_src_o   = PC_BR;
            end
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        reg2loc_o   = 1'b1;
        alu_src_o   = 1'b1;
        mem_read_o  = (class_q == C_LDUR);
        mem_write_o = (class_q == C_STUR);
        if (mem_ready_i) begin
          if (class_q == C_LDUR) begin
            state_d = S_WB;
          end else begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (class_q == C_LDUR);
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_FAULT: fault_o = 1'b1;
      default: state_d = S_FAULT;
    endcase

    // A reset cycle aborts the instruction, so no architectural write may land on that edge.
    if (reset_i) begin
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      instr_done_o = 1'b0;
    end

    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
    retired_d = retired_q + CNT_W'(instr_done_o);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      class_q   <= C_NONE;
      illegal_q <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign illegal_o = illegal_q;
  assign retired_o = retired_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-cycle vector table fed through a scoreboard queue,
// plus hand-built fault, timeout, reset-abort and counter-wrap sequences.
`timescale 1ns/1ps
module tb_multicycle_control;

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] ctrl;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [14:0] ctrl;
  } exp_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_B    = 11'b00010110011;

  logic        clk;
  logic        reset;
  logic [10:0] opcode;
  logic        zero;
  logic        memReady;
  logic        irWrite, pcWrite, reg2loc, aluSrc, memRead, memWrite, memToReg, regWrite;
  logic [1:0]  pcSrc, aluOp;
  logic        instrDone, fault, illegal;
  logic [31:0] retired;
  logic [2:0]  state;

  logic        reset4, zero4, memReady4;
  logic [10:0] opcode4;
  logic        irWrite4, pcWrite4, reg2loc4, aluSrc4, memRead4, memWrite4, memToReg4, regWrite4;
  logic [1:0]  pcSrc4, aluOp4;
  logic        instrDone4, fault4, illegal4;
  logic [3:0]  retired4;
  logic [2:0]  state4;

  int   nApplied;
  int   nMiscompares;
  exp_t sb[$];
  vec_t vecs[$];

  logic [14:0] fWait, fGo, dNop, dB, eR, eLs, eCbT, eCbN, mLd, mSt, mStD, wR, wLd, flt, fltIll;

  multicycle_control dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(memReady),
    .ir_write_o(irWrite), .pc_write_o(pcWrite), .pc_src_o(pcSrc), .reg2loc_o(reg2loc),
    .alu_src_o(aluSrc), .mem_read_o(memRead), .mem_write_o(memWrite), .mem_to_reg_o(memToReg),
    .reg_write_o(regWrite), .alu_op_o(aluOp), .instr_done_o(instrDone), .retired_o(retired),
    .fault_o(fault), .illegal_o(illegal), .state_o(state)
  );

  multicycle_control #(.CNT_W(4), .MEM_TIMEOUT(0)) dut4 (
    .clk_i(clk), .reset_i(reset4), .opcode_i(opcode4), .zero_i(zero4), .mem_ready_i(memReady4),
    .ir_write_o(irWrite4), .pc_write_o(pcWrite4), .pc_src_o(pcSrc4), .reg2loc_o(reg2loc4),
    .alu_src_o(aluSrc4), .mem_read_o(memRead4), .mem_write_o(memWrite4), .mem_to_reg_o(memToReg4),
    .reg_write_o(regWrite4), .alu_op_o(aluOp4), .instr_done_o(instrDone4), .retired_o(retired4),
    .fault_o(fault4), .illegal_o(illegal4), .state_o(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic r2l, input logic as, input logic mr,
                                     input logic mw, input logic m2r, input logic rw,
                                     input logic [1:0] aop, input logic dn, input logic f,
                                     input logic il);
    return {irw, pcw, pcs, r2l, as, mr, mw, m2r, rw, aop, dn, f, il};
  endfunction

  function automatic void addVec(input string name, input logic [10:0] op, input logic z,
                                 input logic rdy, input logic [2:0] st, input logic [14:0] ctrl);
    vec_t v;
    v.name = name; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.ctrl = ctrl;
    vecs.push_back(v);
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [14:0] act;
    act = {irWrite, pcWrite, pcSrc, reg2loc, aluSrc, memRead, memWrite, memToReg, regWrite,
           aluOp, instrDone, fault, illegal};
    nApplied++;
    if (sb.size() == 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard: empty when output was sampled");
    end else begin
      e = sb.pop_front();
      if (state !== e.st || act !== e.ctrl) begin
        nMiscompares++;
        $display("[TB] FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 e.name, state, act, e.st, e.ctrl);
      end
    end
  endtask

  // Drives one cycle of inputs, queues the expected outputs, and checks mid-cycle.
  task automatic applyStimulus(input string name, input logic [10:0] op, input logic z,
                               input logic rdy, input logic [2:0] st, input logic [14:0] ctrl);
    exp_t e;
    opcode = op; zero = z; memReady = rdy;
    e.name = name; e.st = st; e.ctrl = ctrl;
    sb.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; memReady = 1'b1; opcode = '0; zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic threeCycleR(input string name, input logic [10:0] op);
    addVec({name, " fetch"}, op, 0, 1, 0, fGo);
    addVec({name, " decode"}, op, 0, 1, 1, dNop);
    addVec({name, " exec"}, op, 0, 1, 2, eR);
    addVec({name, " wb"}, op, 0, 1, 4, wR);
  endtask

  initial begin
    logic [10:0] nearMiss [4];
    nApplied = 0;
    nMiscompares = 0;
    reset4 = 1'b1; opcode4 = '0; zero4 = 1'b0; memReady4 = 1'b0;

    fWait  = mk(0,0,2'b00,0,0,1,0,0,0,2'b00,0,0,0);
    fGo    = mk(1,1,2'b00,0,0,1,0,0,0,2'b00,0,0,0);
    dNop   = mk(0,0,2'b00,0,0,0,0,0,0,2'b00,0,0,0);
    dB     = mk(0,1,2'b01,0,0,0,0,0,0,2'b00,1,0,0);
    eR     = mk(0,0,2'b00,0,0,0,0,0,0,2'b10,0,0,0);
    eLs    = mk(0,0,2'b00,1,1,0,0,0,0,2'b00,0,0,0);
    eCbT   = mk(0,1,2'b01,1,0,0,0,0,0,2'b01,1,0,0);
    eCbN   = mk(0,0,2'b00,1,0,0,0,0,0,2'b01,1,0,0);
    mLd    = mk(0,0,2'b00,1,1,1,0,0,0,2'b00,0,0,0);
    mSt    = mk(0,0,2'b00,1,1,0,1,0,0,2'b00,0,0,0);
    mStD   = mk(0,0,2'b00,1,1,0,1,0,0,2'b00,1,0,0);
    wR     = mk(0,0,2'b00,0,0,0,0,0,1,2'b00,1,0,0);
    wLd    = mk(0,0,2'b00,0,0,0,0,1,1,2'b00,1,0,0);
    flt    = mk(0,0,2'b00,0,0,0,0,0,0,2'b00,0,1,0);
    fltIll = mk(0,0,2'b00,0,0,0,0,0,0,2'b00,0,1,1);

    addVec("post-reset fetch", OP_ADD, 0, 0, 0, fWait);
    threeCycleR("add", OP_ADD);
    addVec("ldur fetch", OP_LDUR, 0, 1, 0, fGo);
    addVec("ldur decode", OP_LDUR, 0, 1, 1, dNop);
    addVec("ldur exec", OP_LDUR, 0, 1, 2, eLs);
    for (int i = 0; i < 3; i++) addVec("ldur mem wait", OP_STUR, 0, 0, 3, mLd);
    addVec("ldur mem done", OP_STUR, 0, 1, 3, mLd);
    addVec("ldur wb", OP_ADD, 0, 1, 4, wLd);
    addVec("cbz z1 fetch", OP_CBZ, 0, 1, 0, fGo);
    addVec("cbz z1 decode", OP_CBZ, 0, 1, 1, dNop);
    addVec("cbz z1 exec", OP_CBNZ, 1, 1, 2, eCbT);
    addVec("cbnz z1 fetch", OP_CBNZ, 0, 1, 0, fGo);
    addVec("cbnz z1 decode", OP_CBNZ, 0, 1, 1, dNop);
    addVec("cbnz z1 exec", OP_CBNZ, 1, 1, 2, eCbN);
    addVec("cbz z0 fetch", OP_CBZ, 1, 1, 0, fGo);
    addVec("cbz z0 decode", OP_CBZ, 1, 1, 1, dNop);
    addVec("cbz z0 exec", OP_CBZ, 0, 1, 2, eCbN);
    addVec("cbnz z0 fetch", OP_CBNZ, 0, 1, 0, fGo);
    addVec("cbnz z0 decode", OP_CBNZ, 0, 1, 1, dNop);
    addVec("cbnz z0 exec", OP_CBNZ, 0, 1, 2, eCbT);
    addVec("b fetch", OP_B, 0, 1, 0, fGo);
    addVec("b decode", OP_B, 0, 1, 1, dB);
    addVec("stur fetch wait", OP_STUR, 0, 0, 0, fWait);
    addVec("stur fetch", OP_STUR, 0, 1, 0, fGo);
    addVec("stur decode", OP_STUR, 0, 1, 1, dNop);
    addVec("stur exec", OP_STUR, 0, 1, 2, eLs);
    addVec("stur mem wait", OP_LDUR, 0, 0, 3, mSt);
    addVec("stur mem done", OP_LDUR, 0, 1, 3, mStD);
    threeCycleR("sub", OP_SUB);
    threeCycleR("and", OP_AND);
    threeCycleR("orr", OP_ORR);

    doReset();
    checkValue("reset retired", retired, 0);
    foreach (vecs[i]) applyStimulus(vecs[i].name, vecs[i].op, vecs[i].zero, vecs[i].rdy,
                                    vecs[i].st, vecs[i].ctrl);
    checkValue("retired after table", retired, 11);

    // All-zero opcode faults as illegal and only reset recovers.
    doReset();
    applyStimulus("ill fetch", OP_ADD, 0, 1, 0, fGo);
    applyStimulus("ill decode", 11'b0, 0, 1, 1, dNop);
    for (int i = 0; i < 3; i++) applyStimulus("ill hold", OP_B, 0, 1, 5, fltIll);
    doReset();
    applyStimulus("post-fault fetch", OP_B, 0, 1, 0, fGo);
    checkValue("post-fault illegal", {31'b0, illegal}, 0);

    nearMiss[0] = 11'b10001011001;
    nearMiss[1] = 11'b11111000011;
    nearMiss[2] = 11'b10110110000;
    nearMiss[3] = 11'b00010000000;
    foreach (nearMiss[i]) begin
      doReset();
      applyStimulus("near-miss fetch", nearMiss[i], 0, 1, 0, fGo);
      applyStimulus("near-miss decode", nearMiss[i], 0, 1, 1, dNop);
      applyStimulus("near-miss fault", nearMiss[i], 0, 1, 5, fltIll);
    end

    doReset();
    for (int i = 0; i < 15; i++) applyStimulus("fetch wait", OP_ADD, 0, 0, 0, fWait);
    applyStimulus("fetch timeout", OP_ADD, 0, 1, 5, flt);

    doReset();
    for (int i = 0; i < 14; i++) applyStimulus("fetch wait", OP_B, 0, 0, 0, fWait);
    applyStimulus("fetch late ready", OP_B, 0, 1, 0, fGo);
    applyStimulus("late b decode", OP_B, 0, 1, 1, dB);
    applyStimulus("late next fetch", OP_B, 0, 1, 0, fGo);

    doReset();
    applyStimulus("stur to fetch", OP_STUR, 0, 1, 0, fGo);
    applyStimulus("stur to decode", OP_STUR, 0, 1, 1, dNop);
    applyStimulus("stur to exec", OP_STUR, 0, 1, 2, eLs);
    for (int i = 0; i < 15; i++) applyStimulus("stur mem stall", OP_STUR, 0, 0, 3, mSt);
    applyStimulus("mem timeout", OP_STUR, 0, 1, 5, flt);

    // Reset landing on an LDUR memory cycle must abort it without any write or retire.
    doReset();
    applyStimulus("abort fetch", OP_LDUR, 0, 1, 0, fGo);
    applyStimulus("abort decode", OP_LDUR, 0, 1, 1, dNop);
    applyStimulus("abort exec", OP_LDUR, 0, 1, 2, eLs);
    applyStimulus("abort mem", OP_LDUR, 0, 0, 3, mLd);
    reset = 1'b1; memReady = 1'b1;
    @(negedge clk);
    checkValue("abort writes", {29'b0, regWrite, memWrite, instrDone}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus("abort restart", OP_LDUR, 0, 0, 0, fWait);
    checkValue("abort retired", retired, 0);

    @(posedge clk);
    #1;
    reset4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    checkValue("no-timeout stays fetch", {29'b0, state4}, 0);
    memReady4 = 1'b1;
    opcode4 = OP_B;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
    end
    checkValue("cnt4 wrap at 16", {28'b0, retired4}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkValue("cnt4 after 17", {28'b0, retired4}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

  initial begin
    #500000;
    nMiscompares++;
    $display("[TB] FAIL watchdog: bench did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the LEGv8 CPU. It replaces the single-cycle opcode decoder with a registered FSM that sequences FETCH/DECODE/EXEC/MEM/WB. It fully decodes ADD, SUB, AND, ORR, LDUR, STUR, CBZ, CBNZ and B, and waits on a memory ready handshake with a timeout. It sits between the instruction register (opcode field) and the shared multicycle datapath, and also counts retired instructions.

## Interface
- OPCODE_W, 11, opcode field width (instruction[31:21]); values other than 11 are unsupported.
- ALUOP_W, 2, ALU control class width.
- MEM_TIMEOUT, 15, max consecutive wait cycles on mem_ready before FAULT; 0 disables the timeout.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  IR[31:21]; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write, pc_write  out  1  IR load; PC load.
- pc_src  out  2  00 = PC+4, 01 = branch target (old PC + offset, computed in the datapath).
- reg2loc, alu_src, mem_read, mem_write, mem_to_reg, reg_write  out  1  datapath controls.
- alu_op  out  ALUOP_W  00 = add (address), 01 = pass/compare (CB), 10 = R-type funct.
- instr_done  out  1  one-cycle pulse on retire.
- retired  out  CNT_W  retired count; wraps modulo 2^CNT_W.
- fault, illegal  out  1  sticky; illegal = 1 when the fault cause is decode.
- state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.

## Operation
- Decode, full compare:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx.
  - Anything else is illegal.
- The instruction class is latched at DECODE and used by EXEC/MEM/WB, so opcode changes after DECODE are ignored.
- Outputs are a combinational function of the registered state, the latched class and the inputs. Every control not listed for a state is 0.
- FETCH:
  - mem_read = 1.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Illegal opcode: go to FAULT, set illegal.
  - B: pc_write = 1, pc_src = 01, instr_done, go to FETCH.
  - All other classes: go to EXEC.
- EXEC:
  - R-type: alu_src = 0, alu_op = 10, go to WB.
  - LDUR/STUR: reg2loc = 1, alu_src = 1, alu_op = 00, go to MEM.
  - CBZ/CBNZ: reg2loc = 1, alu_op = 01. Branch is taken when (CBZ & zero) or (CBNZ & !zero); when taken, pc_write = 1 and pc_src = 01. Then instr_done, go to FETCH.
- MEM:
  - alu_src = 1, alu_op = 00, reg2loc = 1.
  - LDUR asserts mem_read; STUR asserts mem_write. Both are held until mem_ready.
  - On mem_ready: LDUR goes to WB; STUR pulses instr_done and goes to FETCH.
- WB: reg_write = 1, mem_to_reg = 1 for LDUR only, instr_done, go to FETCH.
- FAULT: all controls 0, fault = 1. Only reset leaves FAULT.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments on each cycle with mem_ready = 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT (illegal = 0).
  - If mem_ready arrives on the same cycle the count would expire, the access completes and no fault is raised.
- retired increments by 1 on each cycle where instr_done = 1.

## Timing
- Reset (synchronous): state = FETCH, retired = 0, fault = illegal = 0, wait counter = 0, latched class = 0.
- On the first cycle after reset, mem_read = 1 and all other outputs are 0.
- Reset asserted mid-instruction aborts it: no instr_done, no reg_write/mem_write on the following edge, count unchanged.
- Cycles per instruction with zero-wait memory (mem_ready held at 1):
  - B: 2. CBZ/CBNZ: 3. R-type: 4. STUR: 4. LDUR: 5.
  - Each mem_ready-low cycle in FETCH or MEM adds 1.
- mem_write/mem_read are held stable for the whole MEM stay; reg_write is high for exactly one cycle per R-type/LDUR.
- instr_done is coincident with the last cycle of the instruction; the next FETCH begins on the following cycle.

## Test plan
- Reset, mem_ready = 1, opcode ADD -> state 0,1,2,4,0; reg_write and instr_done high in cycle 4 only; retired = 1.
- LDUR with mem_ready low for 3 MEM cycles -> 8 cycles total; mem_read high throughout MEM; mem_to_reg = reg_write = 1 in WB.
- CBZ with zero = 1 -> pc_write = 1, pc_src = 01 in EXEC. CBNZ with zero = 1 -> pc_write = 0. Each takes 3 cycles.
- B -> retires in DECODE after 2 cycles, pc_src = 01. Opcode 00000000000 -> FAULT with illegal = 1, stays in FAULT until reset.
- MEM_TIMEOUT = 15 with mem_ready stuck low in FETCH -> FAULT after 15 wait cycles, illegal = 0. Repeat with mem_ready = 1 on cycle 15 -> no fault.
- CNT_W = 4 with 17 B instructions -> retired = 1. Reset asserted during LDUR MEM -> no reg_write, retired = 0, state = FETCH.
